countdown_timer: RTL and testbench



---
 rtl/counter_pkg.sv | 9 +
 rtl/countdown_timer.sv | 80 ++++++++
 tb/tb_countdown_timer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the lab counter blocks.
package counter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } cnt_state_e;

endpackage : counter_pkg

// File: rtl/countdown_timer.sv
// Loadable down-counter with a one-cycle terminal-count pulse.
// Auto-reload turns it into a periodic tick source.
module countdown_timer
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             auto_reload,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] CNT_ZERO = WIDTH'(0);
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

  cnt_state_e       r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_period;
  logic             r_busy;
  logic             r_done;

  // Priority per edge: abort, then load, then enabled decrement in RUN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_count  <= CNT_ZERO;
      r_period <= CNT_ZERO;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (abort) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
        r_count <= CNT_ZERO;
      end else if (load) begin
        r_count  <= load_val;
        r_period <= load_val;
        if (load_val != CNT_ZERO) begin
          r_state <= RUN;
          r_busy  <= 1'b1;
        end else begin
          // Zero-length countdown terminates on the load edge itself.
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
      end else if (r_state == RUN && en) begin
        if (r_count > CNT_ONE) begin
          r_count <= r_count - CNT_ONE;
        end else if (r_count == CNT_ONE) begin
          r_done <= 1'b1;
          if (auto_reload) begin
            r_count <= r_period;
          end else begin
            r_count <= CNT_ZERO;
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end else begin
          // Unreachable in practice; never wrap below zero.
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      end
    end
  end

  assign count = r_count;
  assign busy  = r_busy;
  assign done  = r_done;

endmodule : countdown_timer

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer.
module tb_countdown_timer;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             auto_reload;
  logic             abort;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;

  int checks;
  int errors;

  countdown_timer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .load       (load),
    .load_val   (load_val),
    .auto_reload(auto_reload),
    .abort      (abort),
    .count      (count),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int c, input int b, input int d);
    chk({tag, ".count"}, 32'(count), c);
    chk({tag, ".busy"}, 32'(busy), b);
    chk({tag, ".done"}, 32'(done), d);
  endtask

  initial begin
    int exp_ar[9];
    checks = 0;
    errors = 0;
    rst = 1'b0;
    en = 1'b0;
    load = 1'b0;
    load_val = '0;
    auto_reload = 1'b0;
    abort = 1'b0;

    // Reset state
    tick();
    tick();
    chk_all("reset", 0, 0, 0);
    rst = 1'b1;
    tick();
    chk_all("idle_after_reset", 0, 0, 0);

    // Basic countdown from 4
    load = 1'b1; load_val = 8'd4; en = 1'b1;
    tick();
    chk_all("basic_load", 4, 1, 0);
    load = 1'b0;
    for (int i = 3; i >= 1; i--) begin
      tick();
      chk_all("basic_dec", i, 1, 0);
    end
    tick();
    chk_all("basic_term", 0, 0, 1);
    tick();
    chk_all("basic_hold0", 0, 0, 0);

    // Gated enable: load 3 then en 1,0,0,1,1
    en = 1'b0; load = 1'b1; load_val = 8'd3;
    tick();
    chk_all("gate_load", 3, 1, 0);
    load = 1'b0; en = 1'b1;
    tick();
    chk_all("gate_e1", 2, 1, 0);
    en = 1'b0;
    tick();
    chk_all("gate_e0a", 2, 1, 0);
    tick();
    chk_all("gate_e0b", 2, 1, 0);
    en = 1'b1;
    tick();
    chk_all("gate_e1b", 1, 1, 0);
    tick();
    chk_all("gate_term", 0, 0, 1);

    // Auto-reload period 3
    en = 1'b0; auto_reload = 1'b1; load = 1'b1; load_val = 8'd3;
    tick();
    chk_all("ar_load", 3, 1, 0);
    load = 1'b0; en = 1'b1;
    exp_ar = '{2, 1, 3, 2, 1, 3, 2, 1, 3};
    for (int i = 0; i < 9; i++) begin
      tick();
      chk_all("ar_run", exp_ar[i], 1, (i % 3 == 2) ? 1 : 0);
    end

    // Auto-reload period 1: done every cycle
    load = 1'b1; load_val = 8'd1;
    tick();
    chk_all("ar1_load", 1, 1, 0);
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all("ar1_run", 1, 1, 1);
    end
    abort = 1'b1;
    tick();
    chk_all("ar1_abort", 0, 0, 0);
    abort = 1'b0; auto_reload = 1'b0;

    // Priority: abort beats load at count 2
    en = 1'b0; load = 1'b1; load_val = 8'd4;
    tick();
    load = 1'b0; en = 1'b1;
    tick();
    tick();
    chk_all("prio_at2", 2, 1, 0);
    en = 1'b0; load = 1'b1; load_val = 8'd7; abort = 1'b1;
    tick();
    chk_all("prio_abort", 0, 0, 0);
    abort = 1'b0;

    // Load during RUN restarts countdown
    load_val = 8'd4;
    tick();
    load = 1'b0; en = 1'b1;
    tick();
    tick();
    chk_all("restart_at2", 2, 1, 0);
    load = 1'b1; load_val = 8'd7;
    tick();
    chk_all("restart_load", 7, 1, 0);
    load = 1'b0;
    tick();
    chk_all("restart_dec", 6, 1, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // Zero-length load
    load = 1'b1; load_val = 8'd0;
    tick();
    chk_all("zero_load", 0, 0, 1);
    load = 1'b0;
    tick();
    chk_all("zero_after", 0, 0, 0);

    // Max load 255, no wrap
    load = 1'b1; load_val = 8'd255;
    tick();
    chk_all("max_load", 255, 1, 0);
    load = 1'b0;
    repeat (254) tick();
    chk_all("max_at1", 1, 1, 0);
    tick();
    chk_all("max_term", 0, 0, 1);
    tick();
    chk_all("max_nowrap", 0, 0, 0);

    // Reset mid-RUN, asserted between edges
    load = 1'b1; load_val = 8'd5;
    tick();
    load = 1'b0;
    tick();
    tick();
    chk_all("rst_pre", 3, 1, 0);
    #2;
    rst = 1'b0;
    #1;
    chk_all("rst_async", 0, 0, 0);
    #1;
    rst = 1'b1;
    tick();
    chk_all("rst_resume_idle", 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_countdown_timer
